// File: rtl/snn_pkg.sv
// Shared types and default sizes for the spike event encoder.
package snn_pkg;
  localparam int N_NEURONS_DEF = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int TS_W          = 6;

  typedef enum logic [1:0] {IDLE, REQ, GAP} enc_state_t;
endpackage

// File: rtl/spike_event_encoder_lsb_priority_encoder.sv
// Combinational lowest-set-bit finder; found=0 and idx=0 for an all-zero vector.
module lsb_priority_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);
  // Scanning downward lets the lowest set bit be the final write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spike_event_encoder.sv
// Serializes coalesced spike vectors into address events over a return-to-zero req/ack link.
// Define SPIKE_EVENT_TIMESTAMP_EN to add a per-event timestep output (event_ts).
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  output logic                 event_req,
  output logic [ADDR_W-1:0]    event_addr,
  input  logic                 event_ack,
  output logic                 busy,
  output logic                 spike_overrun
`ifdef SPIKE_EVENT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      event_ts
`endif
);
  enc_state_t             state_q, state_d;
  logic [N_NEURONS-1:0]   pend_q, pend_d;
  logic [N_NEURONS-1:0]   ack_mask, in_mask;
  logic                   req_q, req_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   ovr_q, ovr_d;
  logic [ADDR_W-1:0]      low_idx;
  logic                   low_found;
  logic                   load_evt;

  lsb_priority_encoder #(.N(N_NEURONS), .W(ADDR_W)) u_pe (
    .vec   (pend_q),
    .idx   (low_idx),
    .found (low_found)
  );

  always_comb begin
    ack_mask = '0;
    if (state_q == REQ && event_ack) ack_mask[addr_q] = 1'b1;
    in_mask  = spike_valid ? spike_in : '0;
    // A spike landing on the bit being acked this cycle is a fresh event, not an overrun.
    pend_d   = (pend_q & ~ack_mask) | in_mask;
    ovr_d    = ovr_q | (|(in_mask & pend_q & ~ack_mask));

    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    load_evt = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (low_found) begin
          state_d  = REQ;
          req_d    = 1'b1;
          addr_d   = low_idx;
          load_evt = 1'b1;
        end else begin
          state_d  = IDLE;
          req_d    = 1'b0;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (event_ack) begin
          state_d = GAP;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign event_req     = req_q;
  assign event_addr    = addr_q;
  assign spike_overrun = ovr_q;
  assign busy          = (state_q != IDLE) | (|pend_q);

`ifdef SPIKE_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] ts_out_q, ts_out_d;
  logic [TS_W-1:0] ts_mem_q [N_NEURONS];
  logic [TS_W-1:0] ts_mem_d [N_NEURONS];

  // Stored stamps use the post-increment count, so the first strobe after reset is timestep 1.
  always_comb begin
    ts_cnt_d = spike_valid ? ts_cnt_q + TS_W'(1) : ts_cnt_q;
    ts_mem_d = ts_mem_q;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (in_mask[i]) ts_mem_d[i] = ts_cnt_d;
    end
    ts_out_d = load_evt ? ts_mem_q[low_idx] : ts_out_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      ts_out_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) ts_mem_q[i] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_out_q <= ts_out_d;
      for (int i = 0; i < N_NEURONS; i++) ts_mem_q[i] <= ts_mem_d[i];
    end
  end

  assign event_ts = ts_out_q;
`endif
endmodule

// File: tb/tb_spike_event_encoder.sv
// Scoreboard bench for spike_event_encoder: expected addresses queued at stimulus, checked per event.
module tb_spike_event_encoder;
  import snn_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] spike_in;
  logic        spike_valid;
  logic        event_req;
  logic [3:0]  event_addr;
  logic        event_ack;
  logic        busy;
  logic        spike_overrun;
`ifdef SPIKE_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] event_ts;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  spike_event_encoder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .spike_in      (spike_in),
    .spike_valid   (spike_valid),
    .event_req     (event_req),
    .event_addr    (event_addr),
    .event_ack     (event_ack),
    .busy          (busy),
    .spike_overrun (spike_overrun)
`ifdef SPIKE_EVENT_TIMESTAMP_EN
    ,
    .event_ts      (event_ts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds spike_valid for one cycle and returns at the next negedge.
  task automatic strobe(input logic [15:0] vec);
    spike_in    = vec;
    spike_valid = 1'b1;
    @(negedge clock);
    spike_valid = 1'b0;
    spike_in    = '0;
  endtask

  task automatic get_event(input int stall, input int exp_wait,
                           input logic [15:0] co_spike, input int exp_ts);
    int waited = 0;
    int exp_a  = -1;
    while (!event_req && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!event_req) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_wait >= 0) check("req_latency", waited, exp_wait);
    if (exp_q.size() == 0) check("spurious_event", {28'd0, event_addr}, 32'hFFFF);
    else begin
      exp_a = exp_q.pop_front();
      check("event_addr", {28'd0, event_addr}, exp_a);
    end
`ifdef SPIKE_EVENT_TIMESTAMP_EN
    if (exp_ts >= 0) check("event_ts", {26'd0, event_ts}, exp_ts);
`else
    if (exp_ts > 1000) $display("note: timestamp ignored");
`endif
    repeat (stall) begin
      @(negedge clock);
      check("stall_req", {31'd0, event_req}, 32'd1);
      check("stall_addr", {28'd0, event_addr}, exp_a);
    end
    event_ack = 1'b1;
    if (co_spike != 16'd0) begin
      spike_in    = co_spike;
      spike_valid = 1'b1;
    end
    @(negedge clock);
    event_ack   = 1'b0;
    spike_valid = 1'b0;
    spike_in    = '0;
    check("req_rtz", {31'd0, event_req}, 32'd0);
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clock);
      if (event_req) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    spike_in    = '0;
    spike_valid = 1'b0;
    event_ack   = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_req", {31'd0, event_req}, 32'd0);
    check("rst_addr", {28'd0, event_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, spike_overrun}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Sparse vector drained with immediate acks: 1-cycle gaps, busy falls after last ack
    exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
    strobe(16'h8421);
    check("busy_after_strobe", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) get_event(0, 1, 16'h0, -1);
    check("busy_in_gap", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("busy_drop", {31'd0, busy}, 32'd0);

    // Receiver stall for 20 cycles
    exp_q.push_back(3);
    strobe(16'h0008);
    get_event(20, 1, 16'h0, -1);
    quiet_check("stall_single", 6);
    check("stall_busy", {31'd0, busy}, 32'd0);

    // New vector arrives while event 0 is in flight
    exp_q.push_back(0); exp_q.push_back(1);
    strobe(16'h0001);
    @(negedge clock);
    strobe(16'h0002);
    get_event(0, -1, 16'h0, -1);
    get_event(0, 1, 16'h0, -1);
    check("drain_ovr", {31'd0, spike_overrun}, 32'd0);
    quiet_check("drain_quiet", 4);

    // Ack of bit 2 coincides with a new spike on bit 2: two events, no overrun
    exp_q.push_back(2); exp_q.push_back(2);
    strobe(16'h0004);
    get_event(0, 1, 16'h0004, -1);
    get_event(0, 1, 16'h0, -1);
    check("coinc_ovr", {31'd0, spike_overrun}, 32'd0);
    quiet_check("coinc_quiet", 4);

    // Same bit spiked twice before ack: one event, sticky overrun
    exp_q.push_back(2);
    strobe(16'h0004);
    strobe(16'h0004);
    get_event(0, -1, 16'h0, -1);
    quiet_check("ovr_single", 5);
    check("ovr_set", {31'd0, spike_overrun}, 32'd1);
    @(negedge clock);
    check("ovr_sticky", {31'd0, spike_overrun}, 32'd1);

    // Asynchronous reset in the middle of a request
    strobe(16'h0080);
    for (int i = 0; i < 10 && !event_req; i++) @(negedge clock);
    check("pre_rst_req", {31'd0, event_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, event_req}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ovr", {31'd0, spike_overrun}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    quiet_check("post_rst_quiet", 10);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef SPIKE_EVENT_TIMESTAMP_EN
    // Timestep counter advances on every strobe, including an empty one
    exp_q.push_back(0); exp_q.push_back(4);
    strobe(16'h0001);
    strobe(16'h0000);
    strobe(16'h0010);
    get_event(0, -1, 16'h0, 1);
    get_event(0, 1, 16'h0, 3);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Transmit side of the address-event link into the layer controller.
- Captures the spike vector produced by a neuron array and serializes each set bit into one address event (neuron index) on a req/ack handshake.
- Sits between the neuron array output and the event_addr/event_received/event_ack inputs of the downstream controller.
- Buffers spikes in a coalescing pending register, so new spike vectors may arrive while earlier events are still draining.

Parameters:
N_NEURONS, 16, number of neurons / width of spike vector
ADDR_W, 4, event address width, equals $clog2(N_NEURONS)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
spike_in  input  N_NEURONS  spike vector from neuron array
spike_valid  input  1  single-cycle strobe: spike_in valid this cycle
event_req  output  1  event valid to receiver (drives receiver's event_received)
event_addr  output  ADDR_W  index of spiking neuron, stable while event_req=1
event_ack  input  1  receiver accepted current event
busy  output  1  events pending or in flight
spike_overrun  output  1  sticky: a pending spike was merged with a new spike of the same neuron

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pend=0.
  - event_req=0, event_addr=0, spike_overrun=0.
  - Takes effect immediately, including mid-handshake; an in-flight event is discarded.
- pend register (N_NEURONS bits):
  - ack_mask = onehot(event_addr) when state=REQ and event_ack=1, else 0.
  - in_mask = spike_in when spike_valid=1, else 0.
  - pend_next = (pend & ~ack_mask) | in_mask.
  - Same-cycle ack of bit k and new spike on bit k: bit k stays set (new spike queued); not an overrun.
- spike_overrun: set when (in_mask & pend & ~ack_mask) != 0. Sticky until reset.
- Priority: the lowest-index set bit of pend is sent first. Each address is sent exactly once per pending bit.
- State machine, all outputs registered:
  - IDLE: if pend!=0 -> REQ; event_addr<=lowest set index of pend; event_req<=1.
  - REQ: event_req=1, event_addr held constant.
    - On event_ack=1: event_req<=0 -> GAP.
    - Otherwise stay in REQ indefinitely (no timeout).
  - GAP: event_req=0 for exactly one cycle (return-to-zero, so the receiver sees a fresh edge).
    - If pend!=0 -> REQ with the new lowest index loaded into event_addr; else -> IDLE.
  - Illegal/default state -> IDLE with event_req=0.
- event_ack outside REQ is ignored.
- Latency: spike_valid at cycle t -> pend updated at t+1 -> event_req=1 at t+2. Back-to-back events use 2 cycles minimum (REQ with immediate ack, then GAP).
- busy = (state!=IDLE) | (pend!=0), combinational from registers.
- spike_valid with spike_in=0: no effect.
- All N bits set: N events in ascending order 0..N-1.

Optional Feature:
- Macro: SPIKE_EVENT_TIMESTAMP_EN.
- Defined:
  - Adds output event_ts[5:0], a timestep counter incremented on each spike_valid strobe, wrapping 63->0. Reset value 0.
  - Adds a per-neuron stored copy of the counter value latched when the bit enters pend (when spike_valid=1).
  - event_ts carries the stored value for event_addr, stable while event_req=1.
  - An overrun overwrites the stored value with the newer timestep.
- Undefined: no event_ts port, no counter, no timestamp storage; behaviour otherwise identical.

Decomposition:
- Package snn_pkg:
  - N_NEURONS_DEF=16, ADDR_W_DEF=4, TS_W=6.
  - enc_state_t enum {IDLE, REQ, GAP}.
- Sub-module lsb_priority_encoder (combinational):
  - Input vector of N bits; outputs index of lowest set bit and a found flag.
  - Instantiated once on pend.

Test Plan:
- Reset mid-REQ: assert reset_n=0 while event_req=1 -> event_req=0 immediately, busy=0, no event after release.
- spike_in=16'h8421, spike_valid pulse, event_ack returned 1 cycle after each req -> events 0, 5, 10, 15 in order; event_req low exactly 1 cycle between events; busy drops after the ack of 15.
- Receiver stalls: ack held 0 for 20 cycles -> event_req stays 1 and event_addr stays 3 for spike_in=16'h0008; ack -> single event only.
- New vector 16'h0002 arrives while draining 16'h0001 -> addr 0 then 1; spike_overrun=0.
- spike_in=16'h0004 twice before bit 2 is acked -> one event addr 2, spike_overrun=1. Separately, ack of addr 2 in the same cycle as a new spike on bit 2 -> two events addr 2, spike_overrun=0.
- With SPIKE_EVENT_TIMESTAMP_EN: three strobes of 16'h0001, 16'h0000, 16'h0010 with receiver stalled -> addr 0 ts=1, addr 4 ts=3.
